instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of the multicycle control FSM. Owns the 16-bit program counter and drives the instruction memory read port. Prefetches into a 2-entry instruction buffer and hands `{instr, instr_pc}` to control over a valid/ready handshake. Accepts jump/branch redirects from control, flushing stale prefetches.

## Interface
- `ADDR_W`, 15: memory word-address width (`pc[14:0]`).
- `DATA_W`, 16: instruction width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_addr`  out  ADDR_W  read address to synchronous instruction memory.
- `mem_en`  out  1  read strobe. Memory returns data on `mem_rdata` in the following cycle.
- `mem_rdata`  in  DATA_W  read data, valid the cycle after `mem_en`.
- `instr`  out  DATA_W  head-of-buffer instruction.
- `instr_pc`  out  16  PC of `instr`.
- `instr_valid`  out  1  buffer head valid.
- `instr_ready`  in  1  control accepts head. Transfer occurs when `instr_valid & instr_ready`.
- `redirect`  in  1  one-cycle pulse from control on a taken jump/branch.
- `redirect_pc`  in  16  target PC, sampled when `redirect=1`.
- `fetch_fault`  out  1  fault flag. Present only with `FETCH_FAULT_EN`.

## Operation
- State: `pc` (next address to issue), `inflight` (1 bit), `inflight_pc`, a 2-entry FIFO (`count` 0..2), and FSM {RUN, FAULT}.
- Issue rule, in RUN: `mem_en = (count + inflight - pop) < 2`, where `pop = instr_valid & instr_ready`.
  - `mem_addr = pc[ADDR_W-1:0]`.
  - On issue: `inflight_pc <= pc`, `pc <= pc + 1` (16-bit wrap), `inflight <= 1`. Otherwise `inflight <= 0`.
- Response: if `inflight` was set, `{mem_rdata, inflight_pc}` is pushed at the end of the response cycle. The credit rule guarantees the FIFO never overflows; overflow is a bug and the bench asserts on it.
- `instr_valid = (count != 0) & ~redirect`. `instr`/`instr_pc` come from the FIFO head.
- Redirect has priority over everything else:
  - FIFO is flushed and any response arriving that cycle is dropped.
  - Any handshake in the redirect cycle does not count.
  - `mem_addr = redirect_pc[ADDR_W-1:0]` is issued in the same cycle, `inflight_pc <= redirect_pc`, `pc <= redirect_pc + 1`.
- PC wrap: `16'hFFFF + 1 = 16'h0000`.
- `pc[15]` selects the peripheral space; instructions are never fetched from peripherals. Handling is set by the configuration below.

## Timing
- Reset (async assert): `pc = RESET_PC`, `count = 0`, `inflight = 0`, state RUN, `mem_en = 0` during reset, `instr_valid = 0`, `instr = 0`, `instr_pc = 0`, `fetch_fault = 0`.
- First cycle after reset release: `mem_en = 1`, `mem_addr = RESET_PC`.
- Fetch-to-valid latency: 2 cycles from issue to `instr_valid`. The same latency applies from `redirect` to the target instruction.
- Sustained throughput: 1 instruction/cycle with `instr_ready` held high.
- Backpressure: after `instr_ready` falls, at most 2 entries are held. `mem_en` drops once `count + inflight = 2`.
- Reset mid-operation: all state clears immediately; any memory data returned after reset is ignored.

## Configuration
- `FETCH_FAULT_EN` defined:
  - An issue with `pc[15]=1` (sequential or redirect) enters FAULT instead of issuing.
  - In FAULT: `fetch_fault=1`, `mem_en=0`. Entries already buffered still drain.
  - A `redirect` to an address with bit 15 = 0 returns the block to RUN. Only `reset` or such a redirect clears the fault.
- Undefined:
  - No FAULT state and no `fetch_fault` port.
  - `pc[15]` is ignored for addressing, so `mem_addr` wraps from `15'h7FFF` to `15'h0000`.
  - `instr_pc` still reports the full 16-bit PC.

## Structure
- Shared package `cpu_pkg`: `ADDR_W`, `DATA_W`, `RESET_PC`, the PC type (16 bits), and the peripheral-select bit index (15).
- One sub-module, `fetch_fifo`: 2-entry, width `DATA_W+16`, with push/pop/flush, `count`, and head outputs.
- The FSM, credit logic and PC live in `instr_fetch`.

## Test plan
- Reset release, `instr_ready=1`, memory word = address + 16'h1000:
  - `mem_addr` sequence is 0, 1, 2, …
  - `instr_valid` first high 2 cycles later with `instr=16'h1000`, `instr_pc=0`; then one instruction per cycle.
- Backpressure: `instr_ready=0` for 5 cycles:
  - `count` saturates at 2 and `mem_en` goes low.
  - After release: no instruction is lost or duplicated and `instr_pc` stays contiguous.
- Redirect to 16'h0040 while 2 entries are buffered and 1 is in flight:
  - `mem_addr=16'h0040` in the same cycle.
  - `instr_valid=0` in that cycle and the next; next delivered `instr_pc=16'h0040`.
- Redirect while `instr_ready=1`:
  - The head is not consumed, i.e. not counted as a transfer.
  - Instructions following the old head are never delivered.
- With `FETCH_FAULT_EN`, redirect to 16'h7FFF:
  - 16'h7FFF is fetched, then `fetch_fault=1` and `mem_en=0`.
  - A redirect to 16'h0000 clears the fault.
  - Without the macro, the next `mem_addr` is `15'h0000` and `instr_pc=16'h8000`.
- Assert `reset` asynchronously between clock edges while a fetch is in flight:
  - Outputs clear immediately.
  - The first post-reset `mem_addr` is `RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the fetch stage and its neighbours.
package cpu_pkg;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 16;
  localparam int PC_W       = 16;
  localparam int PERIPH_BIT = 15;
  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

  typedef logic [PC_W-1:0] pc_t;
  typedef enum logic {RUN, FAULT} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer with flush; head is read combinationally.
module fetch_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem;
  logic              rd_ptr, wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, credit-based prefetch into a 2-entry buffer, redirects.
// Optional FETCH_FAULT_EN: fetches from peripheral space (pc[15]) park in FAULT.
module instr_fetch #(
  parameter int              ADDR_W   = cpu_pkg::ADDR_W,
  parameter int              DATA_W   = cpu_pkg::DATA_W,
  parameter logic [15:0]     RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [15:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [15:0]       redirect_pc
`ifdef FETCH_FAULT_EN
  , output logic            fetch_fault
`endif
);
  import cpu_pkg::*;

  localparam int EW = DATA_W + PC_W;

  pc_t           pc, inflight_pc, issue_pc;
  logic          inflight;
  logic [1:0]    count;
  logic          pop, push, credit_ok, issue;
  logic [EW-1:0] head;

  assign instr_valid = (count != 2'd0) & ~redirect;
  assign pop         = instr_valid & instr_ready;
  // A redirect drops whatever response lands in the same cycle.
  assign push        = inflight & ~redirect;
  assign credit_ok   = ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
  assign issue_pc    = redirect ? redirect_pc : pc;

`ifdef FETCH_FAULT_EN
  fetch_state_e state;
  logic         attempt, enter_fault;

  assign attempt     = redirect | ((state == RUN) & credit_ok);
  assign enter_fault = attempt & issue_pc[PERIPH_BIT];
  assign issue       = ~reset & attempt & ~issue_pc[PERIPH_BIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      fetch_fault <= 1'b0;
    end else if (enter_fault) begin
      state       <= FAULT;
      fetch_fault <= 1'b1;
    end else if (issue & redirect) begin
      state       <= RUN;
      fetch_fault <= 1'b0;
    end
  end
`else
  assign issue = ~reset & (redirect | credit_ok);
`endif

  assign mem_en   = issue;
  assign mem_addr = issue_pc[ADDR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= issue_pc;
        pc          <= issue_pc + 16'd1;
      end else if (redirect) begin
        pc          <= redirect_pc;
      end
    end
  end

  fetch_fifo #(.W(EW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({mem_rdata, inflight_pc}),
    .head  (head),
    .count (count)
  );

  assign instr    = head[EW-1:PC_W];
  assign instr_pc = head[PC_W-1:0];
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; expected {instr, pc} pairs go to a queue that
// a negedge monitor drains on every transfer.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] instr, instr_pc;
  logic        instr_valid, instr_ready, redirect;
  logic [15:0] redirect_pc;
`ifdef FETCH_FAULT_EN
  logic        fetch_fault;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  instr_fetch u_dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_en      (mem_en),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_FAULT_EN
    , .fetch_fault (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous memory: word = word address + 0x1000.
  always @(posedge clk) if (mem_en) mem_rdata <= {1'b0, mem_addr} + 16'h1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] pc);
    exp_q.push_back({({1'b0, pc[14:0]} + 16'h1000), pc});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got pc %h instr %h, queue empty", instr_pc, instr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("xfer", {instr, instr_pc}, mon_e);
        end
      end
      chk("no_overflow",
          {31'd0, u_dut.u_fifo.push & ~u_dut.u_fifo.pop & (u_dut.u_fifo.count == 2'd2)}, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    #12;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_head", {instr, instr_pc}, 32'd0);
`ifdef FETCH_FAULT_EN
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0; instr_ready = 1'b1;

    // Streaming: issue pc c in cycle c, first valid two cycles later.
    for (int p = 0; p <= 12; p++) push_exp(16'(p));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("seq_addr", {16'd0, mem_en, mem_addr}, {16'd0, 1'b1, 15'(c)});
      if (c < 2) chk("first_valid_lo", {31'd0, instr_valid}, 32'd0);
      if (c == 2) chk("first_valid_hi", {31'd0, instr_valid}, 32'd1);
      step();
    end

    // Backpressure for 5 cycles: head stays at pc 8, no issue.
    instr_ready = 1'b0;
    for (int c = 10; c < 15; c++) begin
      @(negedge clk);
      chk("bp_mem_en", {31'd0, mem_en}, 32'd0);
      chk("bp_head", {15'd0, instr_valid, instr_pc}, {15'd0, 1'b1, 16'd8});
      step();
    end
    instr_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();

    // Fill the buffer, then redirect while it is full.
    instr_ready = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    chk("redir_addr", {16'd0, mem_en, mem_addr}, {16'd0, 1'b1, 15'h0040});
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    step();
    redirect = 1'b0; instr_ready = 1'b1;
    push_exp(16'h0040); push_exp(16'h0041);
    @(negedge clk);
    chk("redir_valid_next", {31'd0, instr_valid}, 32'd0);
    step();
    step(); step();

    // Redirect with ready high: the masked head must not transfer.
    redirect = 1'b1; redirect_pc = 16'h0100;
    @(negedge clk);
    chk("redir2_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir2_addr", {16'd0, mem_en, mem_addr}, {16'd0, 1'b1, 15'h0100});
    step();
    redirect = 1'b0;
    for (int p = 16'h100; p <= 16'h103; p++) push_exp(16'(p));
    for (int c = 0; c < 5; c++) step();

    // Redirect to the last non-peripheral word.
    redirect = 1'b1; redirect_pc = 16'h7FFF;
    @(negedge clk);
    chk("edge_addr", {16'd0, mem_en, mem_addr}, {16'd0, 1'b1, 15'h7FFF});
    step();
    redirect = 1'b0;
    push_exp(16'h7FFF);
`ifdef FETCH_FAULT_EN
    @(negedge clk);
    chk("fault_block", {30'd0, fetch_fault, mem_en}, 32'd0);
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("fault_hold", {30'd0, fetch_fault, mem_en}, {30'd0, 2'b10});
      step();
    end
`else
    @(negedge clk);
    chk("wrap_addr", {16'd0, mem_en, mem_addr}, {16'd0, 1'b1, 15'h0000});
    push_exp(16'h8000); push_exp(16'h8001);
    step();
    for (int c = 0; c < 3; c++) step();
`endif

    redirect = 1'b1; redirect_pc = 16'h0000;
    @(negedge clk);
    chk("clear_addr", {16'd0, mem_en, mem_addr}, {16'd0, 1'b1, 15'h0000});
    step();
    redirect = 1'b0;
    push_exp(16'h0000); push_exp(16'h0001); push_exp(16'h0002);
`ifdef FETCH_FAULT_EN
    @(negedge clk);
    chk("fault_cleared", {31'd0, fetch_fault}, 32'd0);
`endif
    for (int c = 0; c < 4; c++) step();

    // Asynchronous reset between edges with a fetch in flight.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_outputs", {14'd0, mem_en, instr_valid, instr_pc}, 32'd0);
    chk("arst_instr", {16'd0, instr}, 32'd0);
`ifdef FETCH_FAULT_EN
    chk("arst_fault", {31'd0, fetch_fault}, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_addr", {16'd0, mem_en, mem_addr}, {16'd0, 1'b1, 15'h0000});
    push_exp(16'h0000); push_exp(16'h0001); push_exp(16'h0002);
    step();
    for (int c = 0; c < 4; c++) step();
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
